// File: rtl/switch_traffic_monitor.sv
// Passive end-of-run integrity monitor for an N-port switch: weighted accept/drop/deliver totals plus a drain-and-check FSM.
// Totals update one cycle after the event; per-port readout (MON_PER_PORT_EN) is a 0-cycle mux.
module switch_traffic_monitor #(
    parameter int NUM_PORTS    = 4,
    parameter int CNT_WIDTH    = 16,
    parameter int QUIET_CYCLES = 16,
    parameter int TIMEOUT      = 65535
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS-1:0]           in_valid,
    input  logic [NUM_PORTS-1:0]           in_full,
    input  logic [NUM_PORTS*NUM_PORTS-1:0] in_target,
    input  logic [NUM_PORTS-1:0]           out_valid,
    input  logic                           clr,
    input  logic                           check_start,
    input  logic                           switch_idle,
    output logic [CNT_WIDTH-1:0]           accepted_total,
    output logic [CNT_WIDTH-1:0]           dropped_total,
    output logic [CNT_WIDTH-1:0]           delivered_total,
    output logic [CNT_WIDTH-1:0]           in_flight,
    output logic                           overflow,
    output logic                           check_done,
    output logic                           check_pass,
    output logic                           timeout,
    output logic [CNT_WIDTH-1:0]           loss_count,
    input  logic [$clog2(NUM_PORTS)-1:0]   rd_sel,
    output logic [CNT_WIDTH-1:0]           rd_drop,
    output logic [CNT_WIDTH-1:0]           rd_deliv
);

    localparam int WW = $clog2(NUM_PORTS*NUM_PORTS+1);
    localparam int EW = CNT_WIDTH + WW + 1;
    localparam int QW = $clog2(QUIET_CYCLES+1);
    localparam int TW = $clog2(TIMEOUT+1);
    localparam logic [CNT_WIDTH-1:0] CMAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;

    function automatic logic sat_ovf(input logic [CNT_WIDTH-1:0] a, input logic [WW-1:0] b);
        return (EW'(a) + EW'(b)) > EW'(CMAX);
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_val(input logic [CNT_WIDTH-1:0] a, input logic [WW-1:0] b);
        return sat_ovf(a, b) ? CMAX : a + CNT_WIDTH'(b);
    endfunction

    state_t          state, state_n;
    logic [QW-1:0]   quiet_cnt;
    logic [TW-1:0]   wait_cnt;
    logic            to_hit;
    logic            is_quiet;
    logic [WW-1:0]   port_w [NUM_PORTS];
    logic [WW-1:0]   acc_w, drop_w, del_w;
    logic            any_ovf;

    always_comb begin
        acc_w  = '0;
        drop_w = '0;
        del_w  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            port_w[i] = '0;
            for (int j = 0; j < NUM_PORTS; j++)
                port_w[i] = port_w[i] + WW'(in_target[i*NUM_PORTS+j]);
            if (in_valid[i] && !in_full[i]) acc_w  = acc_w  + port_w[i];
            if (in_valid[i] &&  in_full[i]) drop_w = drop_w + port_w[i];
            del_w = del_w + WW'(out_valid[i]);
        end
        any_ovf = sat_ovf(accepted_total, acc_w) | sat_ovf(dropped_total, drop_w)
                | sat_ovf(delivered_total, del_w);
    end

    assign in_flight  = accepted_total - delivered_total;
    assign is_quiet   = switch_idle && (in_valid == '0) && (out_valid == '0);
    assign check_done = (state == S_DONE);

    always_comb begin
        state_n = state;
        to_hit  = 1'b0;
        case (state)
            S_IDLE:  if (check_start) state_n = S_WAIT;
            S_WAIT: begin
                // A completed quiet window takes priority over a coincident timeout.
                if (quiet_cnt == QW'(QUIET_CYCLES)) begin
                    state_n = S_CHECK;
                end else if (wait_cnt == TW'(TIMEOUT)) begin
                    state_n = S_CHECK;
                    to_hit  = 1'b1;
                end
            end
            S_CHECK: state_n = S_DONE;
            S_DONE:  if (check_start) state_n = S_WAIT;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state           <= S_IDLE;
            quiet_cnt       <= '0;
            wait_cnt        <= '0;
            accepted_total  <= '0;
            dropped_total   <= '0;
            delivered_total <= '0;
            overflow        <= 1'b0;
            check_pass      <= 1'b0;
            timeout         <= 1'b0;
            loss_count      <= '0;
        end else begin
            state           <= state_n;
            accepted_total  <= sat_val(accepted_total, acc_w);
            dropped_total   <= sat_val(dropped_total, drop_w);
            delivered_total <= sat_val(delivered_total, del_w);
            overflow        <= overflow | any_ovf;
            if (state == S_WAIT && state_n == S_WAIT) begin
                wait_cnt  <= wait_cnt + TW'(1);
                quiet_cnt <= is_quiet ? quiet_cnt + QW'(1) : '0;
            end else begin
                wait_cnt  <= '0;
                quiet_cnt <= '0;
            end
            if (to_hit)
                timeout <= 1'b1;
            else if (state == S_DONE && check_start)
                timeout <= 1'b0;
            if (state == S_CHECK) begin
                loss_count <= in_flight;
                check_pass <= (in_flight == '0) && !overflow && !timeout;
            end
        end
    end

`ifdef MON_PER_PORT_EN
    logic [CNT_WIDTH-1:0] drop_cnt  [NUM_PORTS];
    logic [CNT_WIDTH-1:0] deliv_cnt [NUM_PORTS];

    // Per-port counters never exceed the totals, so total saturation already covers their overflow.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (rst || clr) begin
                drop_cnt[i]  <= '0;
                deliv_cnt[i] <= '0;
            end else begin
                if (in_valid[i] && in_full[i])
                    drop_cnt[i] <= sat_val(drop_cnt[i], port_w[i]);
                deliv_cnt[i] <= sat_val(deliv_cnt[i], WW'(out_valid[i]));
            end
        end
    end

    always_comb begin
        rd_drop  = '0;
        rd_deliv = '0;
        if (int'(rd_sel) < NUM_PORTS) begin
            rd_drop  = drop_cnt[rd_sel];
            rd_deliv = deliv_cnt[rd_sel];
        end
    end
`else
    logic unused_rd_sel;
    assign unused_rd_sel = ^rd_sel;
    assign rd_drop       = '0;
    assign rd_deliv      = '0;
`endif

endmodule

// File: tb/tb_switch_traffic_monitor.sv
// Bench for switch_traffic_monitor: directed table, FSM timing sequences, and a randomized run
// against an unbounded-count reference model, applied to a 16-bit and a 4-bit counter instance.
module tb_switch_traffic_monitor;
    localparam int N  = 4;
    localparam int WA = 16;
    localparam int WB = 4;
    localparam int Q  = 16;
    localparam int T  = 100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, clr, check_start, switch_idle;
    logic [N-1:0]   in_valid, in_full, out_valid;
    logic [N*N-1:0] in_target;
    logic [1:0]     rd_sel;

    logic [WA-1:0] acc_a, drop_a, del_a, infl_a, loss_a, rdd_a, rdv_a;
    logic [WB-1:0] acc_b, drop_b, del_b, infl_b, loss_b, rdd_b, rdv_b;
    logic ovf_a, done_a, pass_a, to_a, ovf_b, done_b, pass_b, to_b;

    switch_traffic_monitor #(.NUM_PORTS(N), .CNT_WIDTH(WA), .QUIET_CYCLES(Q), .TIMEOUT(T)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_full(in_full), .in_target(in_target),
        .out_valid(out_valid), .clr(clr), .check_start(check_start), .switch_idle(switch_idle),
        .accepted_total(acc_a), .dropped_total(drop_a), .delivered_total(del_a), .in_flight(infl_a),
        .overflow(ovf_a), .check_done(done_a), .check_pass(pass_a), .timeout(to_a),
        .loss_count(loss_a), .rd_sel(rd_sel), .rd_drop(rdd_a), .rd_deliv(rdv_a));

    switch_traffic_monitor #(.NUM_PORTS(N), .CNT_WIDTH(WB), .QUIET_CYCLES(Q), .TIMEOUT(T)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_full(in_full), .in_target(in_target),
        .out_valid(out_valid), .clr(clr), .check_start(check_start), .switch_idle(switch_idle),
        .accepted_total(acc_b), .dropped_total(drop_b), .delivered_total(del_b), .in_flight(infl_b),
        .overflow(ovf_b), .check_done(done_b), .check_pass(pass_b), .timeout(to_b),
        .loss_count(loss_b), .rd_sel(rd_sel), .rd_drop(rdd_b), .rd_deliv(rdv_b));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: true (unsaturated) event counts since the last clear.
    longint m_acc, m_drop, m_del;
    longint m_pd [N];
    longint m_pv [N];

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic m_ovf(input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (m_acc > mx) || (m_drop > mx) || (m_del > mx);
    endfunction

    function automatic longint m_infl(input int w);
        return (sat(m_acc, w) - sat(m_del, w)) & ((longint'(1) << w) - 1);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_step();
        if (rst || clr) begin
            m_acc = 0; m_drop = 0; m_del = 0;
            for (int i = 0; i < N; i++) begin m_pd[i] = 0; m_pv[i] = 0; end
        end else begin
            for (int i = 0; i < N; i++) begin
                int w;
                w = $countones(in_target[i*N +: N]);
                if (in_valid[i]) begin
                    if (in_full[i]) begin m_drop += w; m_pd[i] += w; end
                    else m_acc += w;
                end
                if (out_valid[i]) begin m_del++; m_pv[i]++; end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = '0; in_full = '0; in_target = '0; out_valid = '0;
        clr = 1'b0; check_start = 1'b0; switch_idle = 1'b1;
    endtask

    task automatic check_model();
        chk("acc_a",  acc_a,  sat(m_acc, WA));
        chk("drop_a", drop_a, sat(m_drop, WA));
        chk("del_a",  del_a,  sat(m_del, WA));
        chk("infl_a", infl_a, m_infl(WA));
        chk("ovf_a",  ovf_a,  m_ovf(WA));
        chk("acc_b",  acc_b,  sat(m_acc, WB));
        chk("drop_b", drop_b, sat(m_drop, WB));
        chk("del_b",  del_b,  sat(m_del, WB));
        chk("infl_b", infl_b, m_infl(WB));
        chk("ovf_b",  ovf_b,  m_ovf(WB));
`ifdef MON_PER_PORT_EN
        chk("rd_drop_a",  rdd_a, sat(m_pd[rd_sel], WA));
        chk("rd_deliv_a", rdv_a, sat(m_pv[rd_sel], WA));
        chk("rd_drop_b",  rdd_b, sat(m_pd[rd_sel], WB));
`else
        chk("rd_drop_a",  rdd_a, 0);
        chk("rd_deliv_a", rdv_a, 0);
`endif
    endtask

    task automatic do_clr();
        clr = 1'b1; tick(); clr = 1'b0;
    endtask

    // Starts a check and counts edges after the check_start edge until check_done.
    task automatic run_check(input int disturb_at, input logic idle_val, output int n);
        in_valid = '0; out_valid = '0;
        check_start = 1'b1; tick(); check_start = 1'b0;
        n = 0;
        while (!done_a && n < 400) begin
            switch_idle = (n + 1 == disturb_at) ? 1'b0 : idle_val;
            tick();
            n++;
        end
        switch_idle = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0]   iv;
        logic [N-1:0]   full;
        logic [N*N-1:0] tgt;
        logic [N-1:0]   ov;
        int             acc;
        int             drop;
        int             del;
    } vec_t;

    vec_t vecs [5];
    int   lat;

    initial begin
        vecs[0] = '{4'b0011, 4'b0010, 16'h001B, 4'b0000,  3, 1, 0};
        vecs[1] = '{4'b1111, 4'b0000, 16'hFFFF, 4'b0101, 19, 1, 2};
        vecs[2] = '{4'b1000, 4'b1000, 16'h6000, 4'b1111, 19, 3, 6};
        vecs[3] = '{4'b0000, 4'b1111, 16'hFFFF, 4'b0000, 19, 3, 6};
        vecs[4] = '{4'b0110, 4'b0010, 16'h0040, 4'b0000, 19, 4, 6};

        idle_inputs();
        rd_sel = 2'd0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_acc", acc_a, 0);   chk("rst_drop", drop_a, 0);
        chk("rst_del", del_a, 0);   chk("rst_infl", infl_a, 0);
        chk("rst_ovf", ovf_a, 0);   chk("rst_done", done_a, 0);
        chk("rst_pass", pass_a, 0); chk("rst_to", to_a, 0);
        chk("rst_loss", loss_a, 0); chk("rst_rdd", rdd_a, 0);

        // Directed table: cumulative expected totals after each cycle.
        for (int k = 0; k < 5; k++) begin
            in_valid = vecs[k].iv; in_full = vecs[k].full;
            in_target = vecs[k].tgt; out_valid = vecs[k].ov;
            tick();
            chk("tbl_acc",  acc_a,  vecs[k].acc);
            chk("tbl_drop", drop_a, vecs[k].drop);
            chk("tbl_del",  del_a,  vecs[k].del);
            chk("tbl_infl", infl_a, vecs[k].acc - vecs[k].del);
        end
        idle_inputs();
        tick();
        chk("tbl_hold_acc", acc_a, 19);

        // Balanced traffic then a clean drain.
        do_clr();
        switch_idle = 1'b0;
        in_valid = 4'b0001; in_target = 16'h0001;
        repeat (5) tick();
        in_valid = '0; out_valid = 4'b0001;
        repeat (5) tick();
        out_valid = '0;
        run_check(0, 1'b1, lat);
        chk("quiet_latency", lat, Q + 2);
        chk("pass_ok", pass_a, 1);
        chk("loss_ok", loss_a, 0);
        chk("to_ok", to_a, 0);
        chk("pass_ok_b", pass_b, 1);

        // Two copies lost; one busy cycle mid-wait restarts the quiet window.
        do_clr();
        in_valid = 4'b0011; in_target = 16'h0077;
        tick();
        in_valid = '0; out_valid = 4'b0011;
        repeat (2) tick();
        out_valid = '0;
        run_check(6, 1'b1, lat);
        chk("restart_latency", lat, Q + 8);
        chk("pass_loss", pass_a, 0);
        chk("loss_two", loss_a, 2);

        // Switch never idle: forced failing check after the timeout.
        do_clr();
        run_check(0, 1'b0, lat);
        chk("timeout_latency", lat, T + 2);
        chk("timeout_flag", to_a, 1);
        chk("timeout_pass", pass_a, 0);
        check_start = 1'b1; tick(); check_start = 1'b0;
        chk("restart_done", done_a, 0);
        chk("restart_to", to_a, 0);

        // Saturation on the 4-bit instance, then clr beating same-cycle traffic.
        do_clr();
        in_valid = 4'b0001; in_target = 16'h000F;
        repeat (5) tick();
        chk("sat_acc_b", acc_b, 15);
        chk("sat_ovf_b", ovf_b, 1);
        chk("sat_acc_a", acc_a, 20);
        chk("sat_ovf_a", ovf_a, 0);
        clr = 1'b1; out_valid = 4'b1111; tick(); clr = 1'b0;
        chk("clr_acc_b", acc_b, 0);
        chk("clr_ovf_b", ovf_b, 0);
        chk("clr_del_a", del_a, 0);
        idle_inputs();

`ifdef MON_PER_PORT_EN
        do_clr();
        in_valid = 4'b0100; in_full = 4'b0100; in_target = 16'h0100;
        repeat (2) tick();
        idle_inputs();
        rd_sel = 2'd2; #1;
        chk("pp_drop2", rdd_a, 2);
        rd_sel = 2'd1; #1;
        chk("pp_drop1", rdd_a, 0);
`endif

        // Randomized traffic against the reference model.
        do_clr();
        for (int c = 0; c < 600; c++) begin
            in_valid  = N'($urandom);
            in_full   = N'($urandom);
            in_target = (N*N)'($urandom);
            out_valid = N'($urandom);
            rd_sel    = 2'($urandom);
            clr       = ($urandom_range(0, 63) == 0);
            tick();
            check_model();
        end
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/switch_traffic_monitor.md
# switch_traffic_monitor

Synthesizable end-of-run integrity monitor for an N-port packet switch: counts weighted ingress acceptances, ingress FIFO rejections and egress deliveries, then runs a drain-and-check sequence that reports internal packet loss. It generalises the fixed 4-port testbench drop counting into parametrised RTL. The block sits beside the switch core, taps the port handshakes passively, and is used in simulation, emulation and silicon debug.

## Interface
- NUM_PORTS, 4, number of switch ports N (2..8)
- CNT_WIDTH, 16, width of every counter
- QUIET_CYCLES, 16, consecutive quiet cycles required before the check
- TIMEOUT, 65535, maximum cycles in WAIT before a forced failing check
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  N  ingress packet presented on port i
- in_full  in  N  ingress FIFO of port i full; a presented packet is rejected
- in_target  in  N*N  target mask of port i at [i*N +: N]
- out_valid  in  N  one packet copy delivered on egress port i
- clr  in  1  synchronous clear of counters, flags and FSM
- check_start  in  1  pulse that starts drain-and-check
- switch_idle  in  1  all switch FIFOs empty
- accepted_total, dropped_total, delivered_total  out  CNT_WIDTH  weighted totals
- in_flight  out  CNT_WIDTH  accepted_total − delivered_total, modulo 2^CNT_WIDTH
- overflow  out  1  sticky; a counter saturated
- check_done  out  1  check result valid
- check_pass  out  1  check result
- timeout  out  1  sticky; WAIT ended by TIMEOUT
- loss_count  out  CNT_WIDTH  in_flight latched in CHECK
- rd_sel  in  clog2(N)  per-port readout select (MON_PER_PORT_EN only)
- rd_drop, rd_deliv  out  CNT_WIDTH  per-port drops of ingress rd_sel and deliveries of egress rd_sel (MON_PER_PORT_EN only)

## Operation
- Weight of an ingress event = popcount of that port's target mask. Accepted: in_valid & !in_full. Dropped: in_valid & in_full.
- Each cycle adds the sum of all port weights, width clog2(N*N+1), to the totals. delivered_total adds popcount(out_valid).
- Counters saturate at all-ones and set overflow. They keep counting in every FSM state.
- in_flight is combinational from the counter registers.
- FSM:
  - IDLE → WAIT on check_start.
  - WAIT: quiet counter increments when switch_idle and in_valid == 0 and out_valid == 0, else clears. Quiet counter == QUIET_CYCLES → CHECK. Wait counter == TIMEOUT → CHECK with timeout=1. check_start is ignored in WAIT.
  - CHECK, one cycle: loss_count ← in_flight; check_pass ← (in_flight == 0) & !overflow & !timeout.
  - DONE: check_done=1 held. check_start → WAIT and clears check_done and timeout.
- clr or rst: all outputs, counters and flags → 0, FSM → IDLE. Counter events in the same cycle are discarded (clr wins).

## Timing
- Event at edge k is visible on the totals after edge k+1; latency 1.
- From the first quiet cycle, check_done rises QUIET_CYCLES+2 cycles later (WAIT count, CHECK, DONE).
- Any non-quiet cycle in WAIT restarts the quiet count.
- Reset values: all outputs 0.
- Saturation: an increment that would exceed 2^CNT_WIDTH−1 clamps to 2^CNT_WIDTH−1 and sets overflow in the same cycle.

## Configuration
- MON_PER_PORT_EN defined: N per-ingress drop counters and N per-egress delivery counters exist, read through rd_sel with a 0-cycle mux. rd_sel ≥ N reads 0.
- MON_PER_PORT_EN undefined: no per-port counters; rd_sel is unused and rd_drop and rd_deliv are tied to 0. Totals behaviour is identical.

## Test plan
- Port 0 target 4'b1011 accepted, port 1 target 4'b0001 rejected, same cycle → next cycle accepted_total=3, dropped_total=1.
- 5 accepted single-target packets, then 5 out_valid pulses, check_start, 16 quiet cycles → check_done=1, check_pass=1, loss_count=0.
- 6 accepted copies, 4 delivered, then quiet → check_pass=0, loss_count=2.
- check_start with switch_idle=0 held; TIMEOUT=100 → check_done after 102 cycles, timeout=1, check_pass=0.
- CNT_WIDTH=4: 20 accepted copies → accepted_total=15, overflow=1. clr in the same cycle as in_valid → all totals 0.
- MON_PER_PORT_EN: drops of 2 on port 2, rd_sel=2 → rd_drop=2. rd_sel=1 → rd_drop=0.
